// File: rtl/operand_fetch_if.sv
// Bundles the decode-in, writeback and ALU-out signals of the operand fetch stage.
// The slave modport is the fetch stage; the master modport is whatever drives it.
`timescale 1ns/1ps
interface operand_fetch_if #(
    parameter int XLEN = 64
);
    logic                   in_valid;
    logic                   in_ready;
    logic [10:0]            in_opcode;
    logic [3:0]             in_instr_type;
    logic [4:0]             in_rs1;
    logic [4:0]             in_rs2;
    logic [4:0]             in_rd;
    logic signed [31:0]     in_imm;
    logic [5:0]             in_shamt;

    logic                   wb_en;
    logic [4:0]             wb_rd;
    logic [XLEN-1:0]        wb_data;

    logic                   out_valid;
    logic                   out_ready;
    logic [10:0]            out_opcode;
    logic [3:0]             out_instr_type;
    logic signed [XLEN-1:0] out_value1;
    logic signed [XLEN-1:0] out_value2;
    logic [31:0]            out_immediate;
    logic [5:0]             out_shamt;
    logic [4:0]             out_rd;

    modport slave (
        input  in_valid, in_opcode, in_instr_type, in_rs1, in_rs2, in_rd, in_imm, in_shamt,
        input  wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_opcode, out_instr_type, out_value1, out_value2,
        output out_immediate, out_shamt, out_rd
    );

    modport master (
        output in_valid, in_opcode, in_instr_type, in_rs1, in_rs2, in_rd, in_imm, in_shamt,
        output wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_instr_type, out_value1, out_value2,
        input  out_immediate, out_shamt, out_rd
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: register file read, busy scoreboard and a one-deep output register.
// Define OPFETCH_BYPASS_EN to forward same-cycle writeback data into the operand reads.
`timescale 1ns/1ps
module operand_fetch #(
    parameter int XLEN = 64
) (
    input  logic           clk,
    input  logic           reset,
    operand_fetch_if.slave bus
);
    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rf_d [32];
    logic [31:0]     busy_q;
    logic [31:0]     busy_d;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;
    logic [31:0]     busy_eff;

    logic            wb_fire;
    logic            hazard;
    logic            in_ready;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    logic            out_valid_q,      out_valid_d;
    logic [10:0]     out_opcode_q,     out_opcode_d;
    logic [3:0]      out_instr_type_q, out_instr_type_d;
    logic [XLEN-1:0] out_value1_q,     out_value1_d;
    logic [XLEN-1:0] out_value2_q,     out_value2_d;
    logic [31:0]     out_immediate_q,  out_immediate_d;
    logic [5:0]      out_shamt_q,      out_shamt_d;
    logic [4:0]      out_rd_q,         out_rd_d;

    assign wb_fire = bus.wb_en && (bus.wb_rd != 5'd0);

    // Index 0 never sets or clears, so busy bit 0 stays at its reset value of 0.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_mask
            if (gi == 0) begin : g_zero
                assign set_mask[gi] = 1'b0;
                assign clr_mask[gi] = 1'b0;
            end else begin : g_nz
                assign set_mask[gi] = accept && (bus.in_rd == 5'(gi));
                assign clr_mask[gi] = wb_fire && (bus.wb_rd == 5'(gi));
            end
        end
    endgenerate

`ifdef OPFETCH_BYPASS_EN
    assign busy_eff = busy_q & ~clr_mask;
`else
    assign busy_eff = busy_q;
`endif

    assign hazard   = bus.in_valid &&
                      (busy_eff[bus.in_rs1] || busy_eff[bus.in_rs2] || busy_eff[bus.in_rd]);
    assign in_ready = reset && (!out_valid_q || bus.out_ready) && !hazard;
    assign accept   = bus.in_valid && in_ready;

    // Set wins over clear when an accept and a writeback target the same index.
    assign busy_d = (busy_q & ~clr_mask) | set_mask;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (wb_fire) begin
            rf_d[bus.wb_rd] = bus.wb_data;
        end
    end

    always_comb begin
        rs1_val = rf_q[bus.in_rs1];
        rs2_val = rf_q[bus.in_rs2];
`ifdef OPFETCH_BYPASS_EN
        if (wb_fire && (bus.wb_rd == bus.in_rs1)) begin
            rs1_val = bus.wb_data;
        end
        if (wb_fire && (bus.wb_rd == bus.in_rs2)) begin
            rs2_val = bus.wb_data;
        end
`endif
    end

    always_comb begin
        out_valid_d      = out_valid_q;
        out_opcode_d     = out_opcode_q;
        out_instr_type_d = out_instr_type_q;
        out_value1_d     = out_value1_q;
        out_value2_d     = out_value2_q;
        out_immediate_d  = out_immediate_q;
        out_shamt_d      = out_shamt_q;
        out_rd_d         = out_rd_q;
        if (accept) begin
            out_valid_d      = 1'b1;
            out_opcode_d     = bus.in_opcode;
            out_instr_type_d = bus.in_instr_type;
            out_value1_d     = rs1_val;
            out_value2_d     = rs2_val;
            out_immediate_d  = bus.in_imm;
            out_shamt_d      = bus.in_shamt;
            out_rd_d         = bus.in_rd;
        end else if (bus.out_ready) begin
            out_valid_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
            busy_q           <= '0;
            out_valid_q      <= 1'b0;
            out_opcode_q     <= '0;
            out_instr_type_q <= '0;
            out_value1_q     <= '0;
            out_value2_q     <= '0;
            out_immediate_q  <= '0;
            out_shamt_q      <= '0;
            out_rd_q         <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= rf_d[i];
            end
            busy_q           <= busy_d;
            out_valid_q      <= out_valid_d;
            out_opcode_q     <= out_opcode_d;
            out_instr_type_q <= out_instr_type_d;
            out_value1_q     <= out_value1_d;
            out_value2_q     <= out_value2_d;
            out_immediate_q  <= out_immediate_d;
            out_shamt_q      <= out_shamt_d;
            out_rd_q         <= out_rd_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_opcode     = out_opcode_q;
    assign bus.out_instr_type = out_instr_type_q;
    assign bus.out_value1     = out_value1_q;
    assign bus.out_value2     = out_value2_q;
    assign bus.out_immediate  = out_immediate_q;
    assign bus.out_shamt      = out_shamt_q;
    assign bus.out_rd         = out_rd_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios then random traffic against
// a transaction-level model of registers, busy bits and output occupancy.
`timescale 1ns/1ps
module tb_operand_fetch;
    localparam int XLEN = 64;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;

    operand_fetch_if #(.XLEN(XLEN)) bus ();

    operand_fetch #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] op;
        logic [3:0]  ty;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [31:0] imm;
        logic [5:0]  sh;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] m_rf [32];
    logic [31:0] m_busy;
    bit          m_ov;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_busy = '0;
        m_ov   = 1'b0;
        sb.delete();
    endtask

    // One clock of stimulus: predict in_ready from the model, queue the expected output on accept.
    task automatic drive_cycle(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input bit wen, input logic [4:0] wrd,
                               input logic [63:0] wdata, input bit ordy);
        logic [31:0] beff;
        bit          haz;
        bit          exp_rdy;
        exp_t        e;
        @(posedge clk);
        #1;
        check("busy_vector", dut.busy_q, m_busy);
        check("out_valid", bus.out_valid, m_ov);
        bus.in_valid      = v;
        bus.in_opcode     = 11'($urandom);
        bus.in_instr_type = 4'($urandom);
        bus.in_rs1        = rs1;
        bus.in_rs2        = rs2;
        bus.in_rd         = rd;
        bus.in_imm        = $urandom;
        bus.in_shamt      = 6'($urandom);
        bus.wb_en         = wen;
        bus.wb_rd         = wrd;
        bus.wb_data       = wdata;
        bus.out_ready     = ordy;
        #1;
        beff = m_busy;
`ifdef OPFETCH_BYPASS_EN
        if (wen && wrd != 0) beff[wrd] = 1'b0;
`endif
        haz     = v && (beff[rs1] || beff[rs2] || beff[rd]);
        exp_rdy = (!m_ov || ordy) && !haz;
        check("in_ready", bus.in_ready, exp_rdy);
        if (v && exp_rdy) begin
            e.op  = bus.in_opcode;
            e.ty  = bus.in_instr_type;
            e.imm = bus.in_imm;
            e.sh  = bus.in_shamt;
            e.rd  = rd;
            e.v1  = (rs1 == 0) ? 64'd0 : m_rf[rs1];
            e.v2  = (rs2 == 0) ? 64'd0 : m_rf[rs2];
`ifdef OPFETCH_BYPASS_EN
            if (wen && wrd != 0 && wrd == rs1) e.v1 = wdata;
            if (wen && wrd != 0 && wrd == rs2) e.v2 = wdata;
`endif
            sb.push_back(e);
            n_acc++;
            $display("accept #%0d t=%0t rs1=%0d rs2=%0d rd=%0d v1=%0h v2=%0h",
                     n_acc, $time, rs1, rs2, rd, e.v1, e.v2);
        end
        if (v && exp_rdy)  m_ov = 1'b1;
        else if (ordy)     m_ov = 1'b0;
        if (wen && wrd != 0) begin
            m_rf[wrd]   = wdata;
            m_busy[wrd] = 1'b0;
        end
        if (v && exp_rdy && rd != 0) m_busy[rd] = 1'b1;
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", dut.busy_q, 0);
        check("rst_out_value1", bus.out_value1, 0);
        check("rst_out_rd", bus.out_rd, 0);
        check("rst_out_opcode", bus.out_opcode, 0);
        for (int i = 0; i < 32; i++) check("rst_regfile", dut.rf_q[i], 0);
        bus.in_valid  = 1'b1;
        bus.in_rs1    = 5'd0;
        bus.in_rs2    = 5'd0;
        bus.in_rd     = 5'd0;
        bus.wb_en     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        model_clear();
        @(posedge clk);
        #1;
        check("rst_hold_out_valid", bus.out_valid, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare the presented output with the oldest expected entry; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", bus.out_valid, 0);
                end else begin
                    mon_e = sb[0];
                    check("out_opcode", bus.out_opcode, mon_e.op);
                    check("out_instr_type", bus.out_instr_type, mon_e.ty);
                    check("out_value1", bus.out_value1, mon_e.v1);
                    check("out_value2", bus.out_value2, mon_e.v2);
                    check("out_immediate", bus.out_immediate, mon_e.imm);
                    check("out_shamt", bus.out_shamt, mon_e.sh);
                    check("out_rd", bus.out_rd, mon_e.rd);
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_opcode     = '0;
        bus.in_instr_type = '0;
        bus.in_rs1        = '0;
        bus.in_rs2        = '0;
        bus.in_rd         = '0;
        bus.in_imm        = '0;
        bus.in_shamt      = '0;
        bus.wb_en         = 1'b0;
        bus.wb_rd         = '0;
        bus.wb_data       = '0;
        bus.out_ready     = 1'b1;
        model_clear();
        #12;
        check("init_out_valid", bus.out_valid, 0);
        check("init_busy", dut.busy_q, 0);
        check("init_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write x5, then a dependent-free add into x6.
        drive_cycle(0, 0, 0, 0, 1, 5, 64'h1234, 1);
        drive_cycle(1, 5, 0, 6, 0, 0, 64'h0, 1);
        // rs1=6 stalls until writeback of x6.
        drive_cycle(1, 6, 0, 7, 0, 0, 64'h0, 1);
        drive_cycle(1, 6, 0, 7, 0, 0, 64'h0, 1);
        drive_cycle(1, 6, 0, 7, 1, 6, 64'hABCD, 1);
        drive_cycle(1, 6, 0, 7, 0, 0, 64'h0, 1);
        drive_cycle(0, 0, 0, 0, 1, 7, 64'h77, 1);
        drive_cycle(0, 0, 0, 0, 0, 0, 64'h0, 1);
        // Writes to x0 are dropped; rd=0 sets no busy bit.
        drive_cycle(0, 0, 0, 0, 1, 0, 64'hFFFF, 1);
        drive_cycle(1, 0, 0, 0, 0, 0, 64'h0, 1);
        drive_cycle(0, 0, 0, 0, 1, 7, 64'h99, 1);
        // Backpressure: one accept, five stalled cycles, then release.
        drive_cycle(1, 1, 2, 3, 0, 0, 64'h0, 0);
        repeat (5) drive_cycle(1, 2, 1, 4, 0, 0, 64'h0, 0);
        drive_cycle(1, 2, 1, 4, 0, 0, 64'h0, 1);
        drive_cycle(0, 0, 0, 0, 0, 0, 64'h0, 0);
        // Reset while out_valid=1 and busy[3]=1.
        reset_mid();

        for (int c = 0; c < 600; c++) begin
            if (c == 300) reset_mid();
            drive_cycle(($urandom_range(0, 3) != 0),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)),
                        ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
                        {$urandom, $urandom},
                        ($urandom_range(0, 9) < 7));
        end
        repeat (4) drive_cycle(0, 0, 0, 0, 0, 0, 64'h0, 1);
        check("scoreboard_drained", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter: XLEN, 64, register/operand width in bits.
REQ-002 SHALL have ports clk (in, 1, clock) and reset (in, 1, asynchronous active-low reset).
REQ-003 SHALL have in_valid/in_ready (in/out, 1 each), handshake for one decoded instruction.
REQ-004 SHALL have in_opcode (in, 11), in_instr_type (in, 4), in_rs1/in_rs2/in_rd (in, 5 each), in_imm (in, 32, signed), in_shamt (in, 6): decoded fields.
REQ-005 SHALL have wb_en (in, 1), wb_rd (in, 5), wb_data (in, XLEN): writeback port.
REQ-006 SHALL have out_valid (out, 1) and out_ready (in, 1): handshake toward the ALU stage.
REQ-007 SHALL have out_opcode (11), out_instr_type (4), out_value1/out_value2 (XLEN, signed), out_immediate (32), out_shamt (6), out_rd (5): ALU operands, all outputs.

Function
REQ-008 SHALL hold a 32 x XLEN register file; x0 reads as 0 and SHALL ignore writes.
REQ-009 SHALL write wb_data to wb_rd at posedge when wb_en=1 and wb_rd!=0.
REQ-010 SHALL keep a 32-bit busy scoreboard; bit 0 permanently 0.
REQ-011 hazard = in_valid and (busy[in_rs1] or busy[in_rs2] or busy[in_rd]), for indices != 0.
REQ-012 in_ready SHALL equal (!out_valid or out_ready) and !hazard, combinational.
REQ-013 Accept = in_valid and in_ready; on accept, output register SHALL load all fields at next posedge and out_valid SHALL be 1 (latency exactly 1 cycle).
REQ-014 out_value1/out_value2 SHALL be register-file reads of in_rs1/in_rs2 sampled at accept.
REQ-015 out_immediate and out_shamt SHALL pass through unchanged; out_value2 SHALL be the rs2 read regardless of in_instr_type.
REQ-016 On accept with in_rd!=0, busy[in_rd] SHALL set at the same posedge.
REQ-017 On wb_en with wb_rd!=0, busy[wb_rd] SHALL clear; same-cycle set and clear of one index SHALL leave it set.
REQ-018 When out_valid=1 and out_ready=0 with no accept, all out_* SHALL hold stable.
REQ-019 When out_valid=1, out_ready=1 and no accept, out_valid SHALL drop to 0 next cycle.
REQ-020 Back-to-back accepts SHALL sustain one instruction per cycle while out_ready=1 and no hazard.

Reset
REQ-021 reset low SHALL asynchronously clear register file, busy, out_valid, and every out_* field to 0.
REQ-022 Instruction in flight at reset assertion SHALL be discarded; first accept possible on first posedge after reset deasserts.
REQ-023 in_ready SHALL be 0 while reset is low.

Configuration
REQ-024 Macro OPFETCH_BYPASS_EN SHALL control writeback bypass.
REQ-025 Defined: a same-cycle wb_en to a nonzero rd SHALL be treated as not busy in REQ-011, and its wb_data SHALL replace the matching rs1/rs2 read.
REQ-026 Undefined: no bypass; operands use the register file's pre-write contents, and busy clears only at the posedge, so the dependent instruction is accepted one cycle later.

Verification
REQ-027 Write x5=0x1234 via wb, then send add rs1=5 rs2=0 rd=6 -> next cycle out_valid=1, out_value1=0x1234, out_value2=0, busy[6]=1.
REQ-028 With busy[6]=1, send rs1=6 -> in_ready=0 until wb_rd=6; with BYPASS_EN accepted in the wb cycle with value1=wb_data; without it accepted one cycle later with the written value.
REQ-029 Hold out_ready=0 after one accept -> in_ready=0, out_* stable for 5 cycles; raise out_ready -> next instruction accepted the same cycle.
REQ-030 wb_en, wb_rd=0, wb_data=0xFFFF -> reads of x0 return 0; instruction with rd=0 sets no busy bit.
REQ-031 Assert reset mid-stream with out_valid=1 and busy[3]=1 -> out_valid=0, busy=0, registers=0 immediately, without waiting for clk.
